alu_execute: RTL

Execute-stage arithmetic unit of the pipelined MIPS core. It consumes the 4-bit `alu_op` from decode-stage ALU control, plus operands from the ID/EX register, and produces a registered 32-bit result for the EX/MEM register. Add, sub, OR and LUI-shift complete in one cycle. Variable shifts (`ALU_sll`, `ALU_sra`) run iteratively, and the unit raises `busy` so the hazard unit stalls decode.

---
 rtl/alu_execute.sv | 131 +++++++++++++
 1 files changed

// File: rtl/alu_execute.sv
// Execute-stage ALU: add/sub/or/lui in 1 cycle, variable shifts iterate 1 bit/cycle (ALU_FAST_SHIFT_EN: barrel, 1 cycle).
// Latency: 1 edge for single-cycle ops, n SHIFT cycles for a shift by n; busy flags the stall.
// Backpressure: result held in DONE until out_ready; in_ready only when IDLE or DONE being consumed.

`ifndef ALU_add
`define ALU_add   4'd1
`define ALU_sub   4'd2
`define ALU_OR    4'd3
`define ALU_sll   4'd4
`define ALU_sra   4'd5
`define ALU_slli  4'd6
`define ALU_undef 4'd15
`endif

module alu_execute (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alu_op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  shamt,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_overflow,
  output logic        out_undef,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        go_shift;
  logic [31:0] sum, diff, res_nxt;
  logic        ovf_nxt, undef_nxt;

  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready && !flush;
  assign sum       = op_a + op_b;
  assign diff      = op_a - op_b;

`ifdef ALU_FAST_SHIFT_EN
  assign go_shift = 1'b0;
  assign busy     = 1'b0;
`else
  logic [4:0] cnt;
  logic       sra_mode;

  assign go_shift = accept && (alu_op == `ALU_sll || alu_op == `ALU_sra) && (shamt != 5'd0);
  assign busy     = (state == SHIFT);
`endif

  always_comb begin
    res_nxt   = 32'h0;
    ovf_nxt   = 1'b0;
    undef_nxt = 1'b0;
    case (alu_op)
      `ALU_add: begin
        res_nxt = sum;
        ovf_nxt = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
      end
      `ALU_sub: begin
        res_nxt = diff;
        ovf_nxt = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
      end
      `ALU_OR:    res_nxt = op_a | op_b;
      `ALU_slli:  res_nxt = {op_b[15:0], 16'h0};
`ifdef ALU_FAST_SHIFT_EN
      `ALU_sll:   res_nxt = op_b << shamt;
      `ALU_sra:   res_nxt = $unsigned($signed(op_b) >>> shamt);
`else
      // Iterative build seeds the shifter with op_b; shamt==0 makes it the final result.
      `ALU_sll:   res_nxt = op_b;
      `ALU_sra:   res_nxt = op_b;
`endif
      `ALU_undef: undef_nxt = 1'b1;
      default:    res_nxt = 32'h0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else if (accept) begin
      state_nxt = go_shift ? SHIFT : DONE;
    end else begin
      case (state)
`ifndef ALU_FAST_SHIFT_EN
        SHIFT:   if (cnt == 5'd1) state_nxt = DONE;
`endif
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      out_result   <= 32'h0;
      out_overflow <= 1'b0;
      out_undef    <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      cnt          <= 5'd0;
      sra_mode     <= 1'b0;
`endif
    end else if (accept) begin
      out_result   <= res_nxt;
      out_overflow <= ovf_nxt;
      out_undef    <= undef_nxt;
`ifndef ALU_FAST_SHIFT_EN
      cnt          <= shamt;
      sra_mode     <= (alu_op == `ALU_sra);
    end else if (state == SHIFT && !flush) begin
      out_result <= sra_mode ? {out_result[31], out_result[31:1]} : {out_result[30:0], 1'b0};
      cnt        <= cnt - 5'd1;
`endif
    end
  end

endmodule
